// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the GPIO bank.
// Register offsets and bus direction encoding.
package gpio_pkg;

  localparam logic [31:0] GPIO_OFS_OUT      = 32'h00;
  localparam logic [31:0] GPIO_OFS_DIR      = 32'h04;
  localparam logic [31:0] GPIO_OFS_IN       = 32'h08;
  localparam logic [31:0] GPIO_OFS_IRQ_EN   = 32'h0C;
  localparam logic [31:0] GPIO_OFS_IRQ_RISE = 32'h10;
  localparam logic [31:0] GPIO_OFS_STAT     = 32'h14;

  localparam logic GPIO_WRITE = 1'b0;
  localparam logic GPIO_READ  = 1'b1;

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: pad synchroniser, history flop and edge vectors.
// GPIO_IRQ_EN adds the history flop and rise/fall outputs.
module gpio_sync_edge #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_pins,
  output logic [WIDTH-1:0] o_sync
`ifdef GPIO_IRQ_EN
  ,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
`endif
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pins};
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] r_hist;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
    end else begin
      r_hist <= o_sync;
    end
  end

  assign o_rise = o_sync & ~r_hist;
  assign o_fall = ~o_sync & r_hist;
`endif

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank, state updates on falling clk.
// GPIO_IRQ_EN enables IRQ_EN/IRQ_RISE/IRQ_STAT and the irq output.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_8004,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      addr,
  input  logic             w_r,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] w_in;
  logic [31:0]      w_ofs;
  logic [31:0]      w_rdata;
  logic             w_wr;
  logic             w_rd;

  assign w_ofs = addr - BASE_ADDR;
  assign w_wr  = en && (w_r == GPIO_WRITE);
  assign w_rd  = en && (w_r == GPIO_READ);

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] r_ien;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_stat;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             r_irq;
`endif

  gpio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .i_pins(gpio_in),
    .o_sync(w_in)
`ifdef GPIO_IRQ_EN
    ,
    .o_rise(w_rise),
    .o_fall(w_fall)
`endif
  );

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      (w_ofs == GPIO_OFS_OUT): w_rdata[WIDTH-1:0] = r_out;
      (w_ofs == GPIO_OFS_DIR): w_rdata[WIDTH-1:0] = r_dir;
      (w_ofs == GPIO_OFS_IN):  w_rdata[WIDTH-1:0] = w_in;
`ifdef GPIO_IRQ_EN
      (w_ofs == GPIO_OFS_IRQ_EN):
        w_rdata[WIDTH-1:0] = r_ien;
      (w_ofs == GPIO_OFS_IRQ_RISE):
        w_rdata[WIDTH-1:0] = r_rise;
      (w_ofs == GPIO_OFS_STAT):
        w_rdata[WIDTH-1:0] = r_stat;
`endif
      default: w_rdata = '0;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_out   <= '0;
      r_dir   <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= w_rd ? w_rdata : '0;
      if (w_wr && (w_ofs == GPIO_OFS_OUT)) begin
        r_out <= wr_data[WIDTH-1:0];
      end
      if (w_wr && (w_ofs == GPIO_OFS_DIR)) begin
        r_dir <= wr_data[WIDTH-1:0];
      end
    end
  end

`ifdef GPIO_IRQ_EN
  // polarity picks the edge; a polarity change alone is not an edge
  assign w_set = ((r_rise & w_rise) | (~r_rise & w_fall)) & r_ien;
  assign w_clr = (w_wr && (w_ofs == GPIO_OFS_STAT)) ?
                 wr_data[WIDTH-1:0] : '0;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_ien  <= '0;
      r_rise <= '0;
      r_stat <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_stat <= (r_stat & ~w_clr) | w_set;
      r_irq  <= |(r_stat & r_ien);
      if (w_wr && (w_ofs == GPIO_OFS_IRQ_EN)) begin
        r_ien <= wr_data[WIDTH-1:0];
      end
      if (w_wr && (w_ofs == GPIO_OFS_IRQ_RISE)) begin
        r_rise <= wr_data[WIDTH-1:0];
      end
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  assign gpio_out = r_out;
  assign gpio_oe  = r_dir;

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed and random bus/pin traffic vs a reference model.
// Expectations follow GPIO_IRQ_EN when it is defined for the build.
module tb_gpio_bank;
  import gpio_pkg::*;

  localparam int          W    = 8;
  localparam int          S    = 2;
  localparam logic [31:0] BASE = 32'h0000_8004;
`ifdef GPIO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         w_r = 1'b1;
  logic [31:0]  addr = '0;
  logic [31:0]  wr_data = '0;
  logic [31:0]  rd_data;
  logic [W-1:0] gpio_in = '0;
  logic [W-1:0] gpio_out;
  logic [W-1:0] gpio_oe;
  logic         irq;

  gpio_bank #(
    .WIDTH      (W),
    .BASE_ADDR  (BASE),
    .SYNC_STAGES(S)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .addr    (addr),
    .w_r     (w_r),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: registers plus a queue of pin samples,
  // newest first; IN is the sample taken S-1 edges back
  logic [W-1:0] m_out, m_dir, m_ien, m_rise, m_stat;
  logic [31:0]  m_rd;
  logic         m_irq;
  logic [W-1:0] pq[$];

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_ien = '0;
    m_rise = '0; m_stat = '0;
    m_rd = '0; m_irq = 1'b0;
    pq.delete();
    for (int i = 0; i <= S; i++) pq.push_back('0);
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    case (o)
      GPIO_OFS_OUT:      return 32'(m_out);
      GPIO_OFS_DIR:      return 32'(m_dir);
      GPIO_OFS_IN:       return 32'(pq[S-1]);
      GPIO_OFS_IRQ_EN:   return IRQ ? 32'(m_ien) : 32'h0;
      GPIO_OFS_IRQ_RISE: return IRQ ? 32'(m_rise) : 32'h0;
      GPIO_OFS_STAT:     return IRQ ? 32'(m_stat) : 32'h0;
      default:           return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic [W-1:0] cur, prev, set, clr;
    logic [31:0]  o;
    bit           is_edge;
    cur  = pq[S-1];
    prev = pq[S];
    set  = '0;
    clr  = '0;
    o    = addr - BASE;
    m_rd  = (en && w_r == GPIO_READ) ? m_read(addr) : 32'h0;
    m_irq = IRQ && ((m_stat & m_ien) != '0);
    for (int i = 0; i < W; i++) begin
      if (m_rise[i]) is_edge = (cur[i] == 1'b1) && (prev[i] == 1'b0);
      else           is_edge = (cur[i] == 1'b0) && (prev[i] == 1'b1);
      if (IRQ && is_edge && m_ien[i]) set[i] = 1'b1;
    end
    if (en && w_r == GPIO_WRITE) begin
      case (o)
        GPIO_OFS_OUT: m_out = wr_data[W-1:0];
        GPIO_OFS_DIR: m_dir = wr_data[W-1:0];
        GPIO_OFS_IRQ_EN:
          if (IRQ) m_ien = wr_data[W-1:0];
        GPIO_OFS_IRQ_RISE:
          if (IRQ) m_rise = wr_data[W-1:0];
        GPIO_OFS_STAT: clr = wr_data[W-1:0];
        default: ;
      endcase
    end
    m_stat = (m_stat & ~clr) | set;
    pq.push_front(gpio_in);
    void'(pq.pop_back());
  endtask

  task automatic step();
    @(negedge clk);
    model_edge();
    #1;
    chk("rd_data", rd_data, m_rd);
    chk("gpio_out", 32'(gpio_out), 32'(m_out));
    chk("gpio_oe", 32'(gpio_oe), 32'(m_dir));
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic acc(input bit e, input logic rd,
                     input logic [31:0] ofs,
                     input logic [31:0] d);
    en = e;
    w_r = rd;
    addr = BASE + ofs;
    wr_data = d;
    step();
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    model_reset();
    chk("mrst_rd", rd_data, 32'h0);
    chk("mrst_out", 32'(gpio_out), 32'h0);
    chk("mrst_oe", 32'(gpio_oe), 32'h0);
    chk("mrst_irq", 32'(irq), 32'h0);
    #1 rst = 1'b1;
  endtask

  initial begin
    logic [31:0] ofs;
    int          r;
    model_reset();
    #1 rst = 1'b0;
    #1;
    chk("rst_rd", rd_data, 32'h0);
    chk("rst_out", 32'(gpio_out), 32'h0);
    chk("rst_oe", 32'(gpio_oe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    #1 rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      acc(1'b1, GPIO_READ, 32'(i * 4), 32'h0);
      chk("rst_reg", rd_data, 32'h0);
    end

    acc(1'b1, GPIO_WRITE, GPIO_OFS_OUT, 32'hFFFF_FFA5);
    acc(1'b1, GPIO_WRITE, GPIO_OFS_DIR, 32'h0000_000F);
    chk("out_pins", 32'(gpio_out), 32'h0000_00A5);
    chk("oe_pins", 32'(gpio_oe), 32'h0000_000F);
    acc(1'b1, GPIO_READ, GPIO_OFS_OUT, 32'h0);
    chk("out_rd", rd_data, 32'h0000_00A5);

    gpio_in = 8'h01;
    acc(1'b1, GPIO_READ, GPIO_OFS_IN, 32'h0);
    chk("in_e1", rd_data, 32'h0);
    acc(1'b1, GPIO_READ, GPIO_OFS_IN, 32'h0);
    chk("in_e2", rd_data, 32'h0);
    acc(1'b1, GPIO_READ, GPIO_OFS_IN, 32'h0);
    chk("in_e3", rd_data, 32'h1);

    gpio_in = 8'h00;
    idle(4);
    acc(1'b1, GPIO_WRITE, GPIO_OFS_IRQ_EN, 32'h1);
    acc(1'b1, GPIO_WRITE, GPIO_OFS_IRQ_RISE, 32'h1);
    gpio_in = 8'h01;
    idle(4);
    chk("irq_set", 32'(irq), 32'(IRQ));
    acc(1'b1, GPIO_READ, GPIO_OFS_STAT, 32'h0);
    chk("stat_set", rd_data, 32'(IRQ));
    acc(1'b1, GPIO_WRITE, GPIO_OFS_STAT, 32'h1);
    acc(1'b1, GPIO_READ, GPIO_OFS_STAT, 32'h0);
    chk("stat_clr", rd_data, 32'h0);
    chk("irq_clr", 32'(irq), 32'h0);
    gpio_in = 8'h00;
    idle(5);
    acc(1'b1, GPIO_READ, GPIO_OFS_STAT, 32'h0);
    chk("stat_fall", rd_data, 32'h0);

    gpio_in = 8'h01;
    idle(2);
    acc(1'b1, GPIO_WRITE, GPIO_OFS_STAT, 32'h1);
    acc(1'b1, GPIO_READ, GPIO_OFS_STAT, 32'h0);
    chk("set_wins", rd_data, 32'(IRQ));
    acc(1'b1, GPIO_WRITE, GPIO_OFS_STAT, 32'h1);

    acc(1'b0, GPIO_WRITE, GPIO_OFS_OUT, 32'h0);
    chk("en0_wr", 32'(gpio_out), 32'h0000_00A5);
    acc(1'b0, GPIO_READ, GPIO_OFS_OUT, 32'h0);
    chk("en0_rd", rd_data, 32'h0);
    acc(1'b1, GPIO_WRITE, 32'h18, 32'hFFFF_FFFF);
    acc(1'b1, GPIO_READ, 32'h18, 32'h0);
    chk("hole_rd", rd_data, 32'h0);
    acc(1'b1, GPIO_READ, GPIO_OFS_OUT, 32'h0);
    chk("hole_keep", rd_data, 32'h0000_00A5);

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(3) == 0) gpio_in = W'($urandom);
      r = $urandom_range(9);
      ofs = (r <= 7) ? 32'(r * 4) : $urandom;
      acc($urandom_range(3) != 0, 1'($urandom), ofs, $urandom);
      if (k == 300) mid_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised general-purpose I/O bank on the CPU data bus: a WIDTH-bit output register, per-pin direction control, synchronised input sampling and per-pin edge-triggered interrupts with sticky, write-1-to-clear status. It replaces the single-register GPIO port and sits on the same memory-mapped peripheral bus. It drives the pad-side out/oe pins and one level interrupt to the CPU.

## Interface
- WIDTH, 32: number of pins, 1..32; register bits above WIDTH read 0, writes ignored
- BASE_ADDR, 32'h0000_8004: byte address of register 0; registers at 4-byte stride
- SYNC_STAGES, 2: input synchroniser depth, ≥2
- clk  in  1  system clock; all state updates on falling edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  bus access strobe; access happens only when en=1 and addr decodes
- addr  in  32  byte address
- w_r  in  1  0 = write, 1 = read
- wr_data  in  32  write data
- rd_data  out  32  read data, registered
- gpio_in  in  WIDTH  asynchronous pad inputs
- gpio_out  out  WIDTH  output data to pads
- gpio_oe  out  WIDTH  output enable, 1 = drive
- irq  out  1  interrupt request, level, registered

## Operation
- Register map, offset from BASE_ADDR: 0x00 OUT (RW), 0x04 DIR (RW, 1 = output), 0x08 IN (RO, synchronised pins), 0x0C IRQ_EN (RW), 0x10 IRQ_RISE (RW, 1 = rising, 0 = falling), 0x14 IRQ_STAT (read, write-1-to-clear).
- Any other address in window or outside: write ignored, rd_data <= 0; rd_data is never tri-stated.
- gpio_out = OUT; gpio_oe = DIR. Output pins still sample into IN (readback of pad).
- Synchroniser: gpio_in passes SYNC_STAGES flops, then one history flop; edge = sync vs history per IRQ_RISE polarity.
- IRQ_STAT[i] sets on selected edge of pin i when IRQ_EN[i]=1; stays set until a 1 is written to that bit. Edges while IRQ_EN[i]=0 are lost and not latched.
- Write-1-to-clear and new edge on same bit in same cycle: set wins.
- irq <= |(IRQ_STAT & IRQ_EN); clearing IRQ_EN masks irq without clearing status.
- Changing IRQ_RISE does not generate an edge by itself.

## Timing
- Reset: OUT, DIR, IRQ_EN, IRQ_STAT, IRQ_RISE, rd_data, irq = 0; synchroniser and history flops = 0; pins therefore inputs.
- Reset asserted mid-operation clears all state immediately, regardless of clk.
- Write: register updates on the falling edge where en=1, w_r=0, addr matches; gpio_out/gpio_oe visible after that edge.
- Read: rd_data valid after the falling edge in the access cycle, held until next falling edge; next cycle without a hit returns 0.
- Input latency: pin change -> IN readable after SYNC_STAGES falling edges; IRQ_STAT set one edge later; irq one edge after that.
- Read of IRQ_STAT in the same cycle as a set returns the pre-set value.

## Configuration
- GPIO_IRQ_EN defined: IRQ_EN, IRQ_RISE, IRQ_STAT and edge logic present as above.
- Undefined: those offsets read 0 and ignore writes, history flop removed, irq tied 0; OUT/DIR/IN unchanged.

## Structure
- Package gpio_pkg: register offset constants (GPIO_OFS_OUT … GPIO_OFS_STAT), read/write encoding constants (GPIO_WRITE = 0, GPIO_READ = 1).
- Sub-module gpio_sync_edge: per-bank synchroniser, history flop, rising/falling edge vector output; instantiated once at WIDTH.

## Test plan
- Reset then read all six registers -> all return 0; gpio_oe = 0, irq = 0.
- WIDTH=8: write OUT=32'hFFFF_FFA5, DIR=32'h0000_000F -> gpio_out=8'hA5, gpio_oe=8'h0F, OUT reads 32'h0000_00A5.
- gpio_in 0x00->0x01, SYNC_STAGES=2 -> IN reads 0x01 after 2 edges, not before.
- IRQ_EN=0x01, IRQ_RISE=0x01, pin0 rises -> IRQ_STAT=0x01, irq=1; write IRQ_STAT=0x01 -> irq=0; falling edge -> no set.
- Write IRQ_STAT=0x01 in same cycle as new pin0 rising edge -> IRQ_STAT stays 0x01.
- Access with en=0 or addr=BASE_ADDR+0x18 -> no register change, rd_data=0.
